// File: rtl/fifo_pkg.sv
// Shared constants for the byte-stream FIFO.
package fifo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  // One extra bit so the count can represent DEPTH itself.
  localparam int unsigned CNT_W  = ADDR_W + 1;

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for the FIFO; slave is the FIFO side.
interface fifo_if;
  import fifo_pkg::*;

  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              empty;
  logic              full;

  modport master (
    output wr, data_in, rd,
    input  data_out, data_out_valid, empty, full
  );

  modport slave (
    input  wr, data_in, rd,
    output data_out, data_out_valid, empty, full
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointers, occupancy count, status flags and registered read data.
module fifo
  import fifo_pkg::*;
(
  input  logic    clk_i,
  input  logic    clear_ni,
  fifo_if.slave   bus_io
);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              empty, full;
  logic              wr_en, rd_en;

  // Flags come from the registered count only, so requests never reach them combinationally.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  assign wr_en = bus_io.wr && !full;
  assign rd_en = bus_io.rd && !empty;

  fifo_mem u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (bus_io.data_in),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;

    if (wr_en) begin
      wptr_d = wptr_q + ADDR_W'(1);
    end
    if (rd_en) begin
      rptr_d  = rptr_q + ADDR_W'(1);
      dout_d  = mem_rdata;
      valid_d = 1'b1;
    end

    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus_io.data_out       = dout_q;
  assign bus_io.data_out_valid = valid_q;
  assign bus_io.empty          = empty;
  assign bus_io.full           = full;

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the FIFO with hand-computed expected values.
module tb_fifo;

  logic clk_i    = 1'b0;
  logic clear_ni = 1'b0;

  fifo_if u_if ();

  fifo u_dut (
    .clk_i    (clk_i),
    .clear_ni (clear_ni),
    .bus_io   (u_if.slave)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] din, input logic rd);
    u_if.wr      = wr;
    u_if.data_in = din;
    u_if.rd      = rd;
  endtask

  task automatic fill_0_to_7();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);

    // Reset held with random requests
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      step();
      check_eq("rst_empty", u_if.empty, 1);
      check_eq("rst_full", u_if.full, 0);
      check_eq("rst_dout", u_if.data_out, 0);
      check_eq("rst_valid", u_if.data_out_valid, 0);
    end
    drive(1'b0, 8'h00, 1'b0);
    clear_ni = 1'b1;
    step();
    step();
    check_eq("idle_empty", u_if.empty, 1);
    check_eq("idle_full", u_if.full, 0);
    check_eq("idle_dout", u_if.data_out, 0);
    check_eq("idle_valid", u_if.data_out_valid, 0);

    // Fill and drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
      if (i == 6) check_eq("fill7_full", u_if.full, 0);
    end
    drive(1'b0, 8'h00, 1'b0);
    check_eq("fill_full", u_if.full, 1);
    check_eq("fill_empty", u_if.empty, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      step();
      check_eq("drain_dout", u_if.data_out, 32'(i));
      check_eq("drain_valid", u_if.data_out_valid, 1);
    end
    drive(1'b0, 8'h00, 1'b0);
    step();
    check_eq("drain_empty", u_if.empty, 1);
    check_eq("drain_valid_lo", u_if.data_out_valid, 0);

    // Writes while full are dropped
    fill_0_to_7();
    for (int i = 8; i < 12; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
      check_eq("ovf_full", u_if.full, 1);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      step();
      check_eq("ovf_dout", u_if.data_out, 32'(i));
      check_eq("ovf_valid", u_if.data_out_valid, 1);
    end
    step();
    check_eq("udf_valid", u_if.data_out_valid, 0);
    check_eq("udf_dout_hold", u_if.data_out, 32'h07);
    check_eq("udf_empty", u_if.empty, 1);

    // Read and write together while full
    fill_0_to_7();
    drive(1'b1, 8'hAA, 1'b1);
    step();
    check_eq("rwf_dout", u_if.data_out, 32'h00);
    check_eq("rwf_valid", u_if.data_out_valid, 1);
    check_eq("rwf_full", u_if.full, 0);
    drive(1'b1, 8'hBB, 1'b0);
    step();
    check_eq("rwf_refull", u_if.full, 1);
    check_eq("rwf_valid_lo", u_if.data_out_valid, 0);
    drive(1'b1, 8'hCC, 1'b0);
    step();
    check_eq("rwf_stay_full", u_if.full, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      step();
      check_eq("rwf_dout_seq", u_if.data_out, (i < 7) ? 32'(i + 1) : 32'hBB);
      check_eq("rwf_valid_seq", u_if.data_out_valid, 1);
    end
    drive(1'b0, 8'h00, 1'b0);
    step();
    check_eq("rwf_empty", u_if.empty, 1);

    // Asynchronous reset mid-operation, then reads on empty
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    check_eq("pre_rst_dout", u_if.data_out, 32'h40);
    clear_ni = 1'b0;
    #1;
    check_eq("async_empty", u_if.empty, 1);
    check_eq("async_dout", u_if.data_out, 0);
    check_eq("async_valid", u_if.data_out_valid, 0);
    step();
    clear_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      step();
      check_eq("rde_valid", u_if.data_out_valid, 0);
      check_eq("rde_dout", u_if.data_out, 0);
      check_eq("rde_empty", u_if.empty, 1);
    end
    drive(1'b1, 8'h55, 1'b0);
    step();
    check_eq("w55_empty", u_if.empty, 0);
    drive(1'b0, 8'h00, 1'b1);
    step();
    check_eq("r55_dout", u_if.data_out, 32'h55);
    check_eq("r55_valid", u_if.data_out_valid, 1);

    // Both ports active at half level, wrapping the pointers
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(8'h14 + i), 1'b1);
      step();
      check_eq("mid_dout", u_if.data_out, 32'(8'h10 + i));
      check_eq("mid_valid", u_if.data_out_valid, 1);
      check_eq("mid_empty", u_if.empty, 0);
      check_eq("mid_full", u_if.full, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      step();
      check_eq("mid_tail", u_if.data_out, 32'(8'h1C + i));
    end
    drive(1'b0, 8'h00, 1'b0);
    step();
    check_eq("mid_end_empty", u_if.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock FIFO, 8-bit data, depth 8.
- Buffers a byte stream between a producer (wr/data_in) and a consumer (rd/data_out).
- Provides empty/full status and a registered read-data valid strobe.
- Writes on full and reads on empty are ignored without corrupting internal state.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two.
- ADDR_W, 3, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- clear  input  1  asynchronous, active-low reset.
- wr  input  1  write request.
- data_in  input  DATA_W  write data.
- rd  input  1  read request.
- data_out  output  DATA_W  read data, registered.
- data_out_valid  output  1  high for one cycle when data_out carries a newly read word.
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds DEPTH words.

Behaviour:
- Reset (clear=0, asynchronous, no clock needed):
  - write pointer, read pointer and count = 0.
  - data_out = 0, data_out_valid = 0, empty = 1, full = 0.
  - Storage contents need not be reset.
- Accepted write: wr_en = wr && !full, using full as registered at that edge. On accept, mem[wptr] <= data_in and wptr increments, wrapping DEPTH-1 -> 0.
- Accepted read: rd_en = rd && !empty. On accept, data_out <= mem[rptr], rptr increments with wrap, and data_out_valid <= 1 the same edge. Read latency is 1 cycle from the sampled rd.
- No accepted read: data_out_valid <= 0; data_out holds its last value.
- Count update:
  - +1 when wr_en && !rd_en.
  - -1 when rd_en && !wr_en.
  - Unchanged when both or neither.
  - Count always stays within 0..DEPTH. A rejected write must never change count.
- Flags: empty = (count==0), full = (count==DEPTH). Both are registered or derived from registered count; no combinational path from wr/rd.
- Boundary cases:
  - wr && rd while full: read accepted, write ignored; count becomes DEPTH-1, full drops next cycle.
  - wr && rd while empty: write accepted, read ignored, data_out_valid = 0; count becomes 1.
  - wr && rd otherwise: both accepted, count unchanged, pointers both advance.
  - wr while full: ignored; no pointer or count change; the stored data is not overwritten.
  - rd while empty: ignored; data_out unchanged, data_out_valid = 0.
  - Pointer wrap-around is transparent; ordering is strict first-in first-out.
  - Reset mid-operation: all state is discarded immediately. Outputs take their reset values while clear=0. Operation resumes on the first rising edge after clear returns high.

Decomposition:
- Package fifo_pkg holds the DATA_W, DEPTH and ADDR_W constants.
- One sub-module, fifo_mem: DEPTH x DATA_W register array with a synchronous write port and a read port indexed by rptr.
- The top level holds pointers, count, flags and output registers.

Test Plan:
- Reset: clear=0 with random wr/rd -> empty=1, full=0, data_out=0, data_out_valid=0. After release with no requests, outputs stay at those values.
- Fill and drain:
  - Write 0x00..0x07 on 8 consecutive cycles -> full=1 after the 8th edge, empty=0.
  - Then rd for 8 cycles -> data_out = 0x00..0x07 in order, each with data_out_valid=1 one cycle after rd.
  - Afterwards empty=1, data_out_valid=0.
- Write while full:
  - Fill with 0x00..0x07, keep wr=1 with data_in=0x08..0x0B -> full stays 1.
  - Drain -> reads 0x00..0x07 only; 0x08..0x0B are never seen.
- Read and write when full:
  - Fill, then hold wr=1 with one cycle of rd=1 -> data_out=0x00, data_out_valid=1; the concurrent write is discarded; full=0 for one cycle.
  - Next cycle wr alone -> full=1 again.
  - Further writes leave full=1; a full drain returns exactly 8 words.
- Read on empty:
  - After reset, rd=1 for 3 cycles -> data_out_valid=0 and data_out=0 throughout.
  - Then write 0x55 -> empty=0; a subsequent rd returns 0x55 with valid.
- Simultaneous read and write mid-level with wrap-around:
  - Pre-load 4 words, then wr && rd for 12 cycles -> count stays 4, empty=0, full=0.
  - Data comes out in write order across the pointer wrap.
